// File: rtl/dapa_loader_pkg.sv
// dapa_loader_pkg: shared definitions for the DAPA2014 serial program loader.
//   - state_t              : loader FSM states
//   - PROG_ADDR_W / _DATA_W: program memory geometry fixed by the ISA
//   - COUNT_ZERO_MEANS_256 : a COUNT byte of 0x00 announces a full 256-word image
//   - frame_words()        : COUNT byte -> number of words in the frame
//   - csum_step()          : running XOR checksum update
package dapa_loader_pkg;

  localparam int PROG_ADDR_W = 8;
  localparam int PROG_DATA_W = 16;

  localparam bit COUNT_ZERO_MEANS_256 = 1'b1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HI    = 3'd1,
    LO    = 3'd2,
    WRITE = 3'd3,
    CHECK = 3'd4,
    DONE  = 3'd5,
    ERROR = 3'd6
  } state_t;

  // Word count announced by a COUNT byte; 0x00 stands for a full memory image.
  function automatic logic [PROG_ADDR_W:0] frame_words(input logic [7:0] count);
    if (COUNT_ZERO_MEANS_256 && (count == 8'h00)) begin
      return 9'h100;
    end else begin
      return {1'b0, count};
    end
  endfunction

  // One step of the frame checksum (plain XOR over COUNT and data bytes).
  function automatic logic [7:0] csum_step(input logic [7:0] csum, input logic [7:0] data);
    return csum ^ data;
  endfunction

endpackage

// File: rtl/loader_timer.sv
// loader_timer: inter-byte idle counter for the program loader.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   clear     : zero the count (byte accepted, restart, or not in a timed state)
//   enable    : count this cycle (loader is waiting for a byte inside a frame)
//   expired   : count has reached TIMEOUT_CYCLES-1 while enabled; a missing
//               byte in this cycle means the frame has timed out
// TIMEOUT_CYCLES = 0 disables the timer (expired never rises).
module loader_timer
  import dapa_loader_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : {CW{1'b0}};
  localparam logic [CW-1:0] ONE  = {{(CW-1){1'b0}}, 1'b1};

  logic [CW-1:0] count_r;

  // Idle-cycle counter; saturates at LAST so it can never wrap back to zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= {CW{1'b0}};
    end else if (clear) begin
      count_r <= {CW{1'b0}};
    end else if (enable && (count_r != LAST)) begin
      count_r <= count_r + ONE;
    end
  end

  // Expiry flag for the FSM; the FSM gives an accept in the same cycle priority.
  always_comb begin
    expired = (TIMEOUT_CYCLES > 0) && enable && (count_r == LAST);
  end

endmodule

// File: rtl/prog_loader.sv
// prog_loader: serial program loader for the DAPA2014 instruction memory.
// Receives a frame COUNT, {hi,lo} x N, CSUM from the UART receiver, writes the
// big-endian words to program RAM at addresses 0,1,2,... and releases the CPU
// once the XOR checksum matches.
// Ports:
//   clk, reset     : clock, asynchronous active-high reset
//   start          : re-arm / abort (level, sampled every cycle)
//   rx_data/valid  : incoming byte stream
//   rx_ready       : loader accepts a byte on rx_valid && rx_ready
//   mem_addr/wdata : program RAM write port, mem_we is a one-cycle strobe
//   cpu_hold       : holds the processor in reset while high
//   done / error   : load finished OK / checksum mismatch or timeout
//   words_loaded   : words written in the current frame
module prog_loader
  import dapa_loader_pkg::*;
#(
  parameter int ADDR_W         = PROG_ADDR_W,
  parameter int DATA_W         = PROG_DATA_W,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              cpu_hold,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded
);

  localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   WORDS_ONE = {{ADDR_W{1'b0}}, 1'b1};

  state_t          state_r;
  logic [ADDR_W:0] n_words_r;
  logic [7:0]      csum_r;
  logic [7:0]      hi_byte_r;
  logic            start_pend_r;

  logic            accept_s;
  logic            restart_s;
  logic            counting_s;
  logic            timer_clear_s;
  logic            timer_expired_s;
  logic [ADDR_W:0] words_next_s;

  // Handshake, restart and timer control decoded from the current state.
  always_comb begin
    accept_s      = rx_valid && rx_ready;
    // A restart never interrupts WRITE; a start seen there is replayed afterwards.
    restart_s     = (start || start_pend_r) && (state_r != WRITE);
    counting_s    = (state_r == HI) || (state_r == LO) || (state_r == CHECK);
    timer_clear_s = accept_s || restart_s || !counting_s;
    words_next_s  = words_loaded + WORDS_ONE;
  end

  loader_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst    (reset),
    .clear  (timer_clear_s),
    .enable (counting_s),
    .expired(timer_expired_s)
  );

  // Loader FSM with all outputs registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= IDLE;
      n_words_r    <= {(ADDR_W+1){1'b0}};
      csum_r       <= 8'h00;
      hi_byte_r    <= 8'h00;
      start_pend_r <= 1'b0;
      rx_ready     <= 1'b1;
      mem_addr     <= {ADDR_W{1'b0}};
      mem_wdata    <= {DATA_W{1'b0}};
      mem_we       <= 1'b0;
      cpu_hold     <= 1'b1;
      done         <= 1'b0;
      error        <= 1'b0;
      words_loaded <= {(ADDR_W+1){1'b0}};
    end else begin
      mem_we <= 1'b0;
      if (restart_s) begin
        // Restart wins over a byte accepted in the same cycle; that byte is lost.
        state_r      <= IDLE;
        csum_r       <= 8'h00;
        start_pend_r <= 1'b0;
        rx_ready     <= 1'b1;
        mem_addr     <= {ADDR_W{1'b0}};
        cpu_hold     <= 1'b1;
        done         <= 1'b0;
        error        <= 1'b0;
        words_loaded <= {(ADDR_W+1){1'b0}};
      end else begin
        case (state_r)
          IDLE: begin
            if (accept_s) begin
              n_words_r <= (ADDR_W+1)'(frame_words(rx_data));
              csum_r    <= rx_data;
              state_r   <= HI;
            end
          end
          HI: begin
            if (accept_s) begin
              hi_byte_r <= rx_data;
              csum_r    <= csum_step(csum_r, rx_data);
              state_r   <= LO;
            end else if (timer_expired_s) begin
              state_r  <= ERROR;
              rx_ready <= 1'b0;
              error    <= 1'b1;
              cpu_hold <= 1'b1;
            end
          end
          LO: begin
            if (accept_s) begin
              mem_wdata <= DATA_W'({hi_byte_r, rx_data});
              csum_r    <= csum_step(csum_r, rx_data);
              mem_we    <= 1'b1;
              rx_ready  <= 1'b0;
              state_r   <= WRITE;
            end else if (timer_expired_s) begin
              state_r  <= ERROR;
              rx_ready <= 1'b0;
              error    <= 1'b1;
              cpu_hold <= 1'b1;
            end
          end
          WRITE: begin
            // mem_we was raised on entry and drops on this exit edge.
            mem_addr     <= mem_addr + ADDR_ONE;
            words_loaded <= words_next_s;
            rx_ready     <= 1'b1;
            if (start) begin
              start_pend_r <= 1'b1;
            end
            if (words_next_s == n_words_r) begin
              state_r <= CHECK;
            end else begin
              state_r <= HI;
            end
          end
          CHECK: begin
            if (accept_s) begin
              rx_ready <= 1'b0;
              if (rx_data == csum_r) begin
                state_r  <= DONE;
                done     <= 1'b1;
                cpu_hold <= 1'b0;
              end else begin
                state_r  <= ERROR;
                error    <= 1'b1;
                cpu_hold <= 1'b1;
              end
            end else if (timer_expired_s) begin
              state_r  <= ERROR;
              rx_ready <= 1'b0;
              error    <= 1'b1;
              cpu_hold <= 1'b1;
            end
          end
          DONE: begin
            rx_ready <= 1'b0;
          end
          ERROR: begin
            rx_ready <= 1'b0;
          end
          default: begin
            state_r  <= ERROR;
            rx_ready <= 1'b0;
            error    <= 1'b1;
            cpu_hold <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Serial program loader that writes the DAPA2014 16-bit instruction memory. It is the writer side of the program memory, which the processor's fetch only ever reads.
- Consumes a byte stream from the UART receiver, assembles big-endian instruction words and writes them to program RAM at addresses 0,1,2…
- Verifies an XOR checksum, then releases the CPU from hold.

Parameters:
- ADDR_W, 8: program memory address width; the ISA fixes it at 8.
- DATA_W, 16: instruction width; the ISA fixes it at 16.
- TIMEOUT_CYCLES, 50000: maximum idle cycles between bytes inside a frame. 0 disables the timeout.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous reset, active-high.
- start  in  1  re-arm or abort; level-sampled each cycle.
- rx_data  in  8  incoming byte.
- rx_valid  in  1  rx_data is valid.
- rx_ready  out  1  loader can accept a byte; transfer happens when rx_valid && rx_ready on a clk edge.
- mem_addr  out  ADDR_W  program RAM write address.
- mem_wdata  out  DATA_W  program RAM write data.
- mem_we  out  1  write strobe, one cycle per word.
- cpu_hold  out  1  holds the processor in reset while high.
- done  out  1  load completed and checksum OK.
- error  out  1  checksum mismatch or timeout.
- words_loaded  out  ADDR_W+1  number of words written in the current frame.

Behaviour:
- Clock and reset: one clock (clk). reset is asynchronous and active-high. All outputs are registered.
- Reset values: state=IDLE, rx_ready=1, mem_addr=0, mem_wdata=0, mem_we=0, cpu_hold=1, done=0, error=0, words_loaded=0, csum=0, timer=0.
- Frame format: COUNT, then 2×N bytes (hi, lo per word), then CSUM.
  - N = COUNT, except COUNT=0x00 means 256.
  - CSUM = XOR of COUNT and every data byte.
- rx_ready is 1 in IDLE, HI, LO and CHECK, and 0 in WRITE, DONE and ERROR.
- IDLE: on accept, N←COUNT (0 gives 256), csum←byte, go to HI. No timeout runs in IDLE.
- HI: on accept, hi_reg←byte, csum^=byte, go to LO.
- LO: on accept, mem_wdata←{hi_reg,byte}, csum^=byte, go to WRITE.
- WRITE (exactly one cycle):
  - mem_we=1, with mem_addr and mem_wdata stable.
  - On exit, mem_addr←mem_addr+1 (wraps 255→0) and words_loaded←words_loaded+1.
  - If the new words_loaded==N, go to CHECK; otherwise go to HI.
- Byte-to-write latency: the last byte of a word is accepted at edge k; mem_we is high in the cycle after edge k.
- CHECK: on accept, go to DONE if byte==csum, otherwise go to ERROR.
- DONE: done=1, cpu_hold=0. The state is held until start.
- ERROR: error=1, cpu_hold=1. The state is held until start. Words already written are left in RAM.
- start, in any state except WRITE:
  - Next state is IDLE.
  - mem_addr=0, words_loaded=0, done=0, error=0, cpu_hold=1, csum=0, timer=0.
- start during WRITE: the write completes, start is latched, and the restart takes effect on the following cycle.
- start and an accepted byte in the same cycle: start wins and the byte is dropped. rx_ready still read 1, so the sender must re-send the frame.
- Timeout (TIMEOUT_CYCLES>0):
  - timer counts cycles in HI, LO and CHECK with no accept, and clears on each accept.
  - timer==TIMEOUT_CYCLES-1 with no accept in that cycle → ERROR on the next edge.
  - An accept in that same cycle is honoured and no error is raised.
- Async reset mid-WRITE: mem_we drops immediately and no partial state is kept.

Decomposition:
- Package dapa_loader_pkg holds:
  - state enum {IDLE, HI, LO, WRITE, CHECK, DONE, ERROR};
  - constants PROG_ADDR_W=8 and PROG_DATA_W=16;
  - COUNT_ZERO_MEANS_256.
- One sub-module is natural: loader_timer (TIMEOUT_CYCLES counter with clear/enable inputs and an expired output). Everything else is a single FSM.

Test Plan:
1. Frame 09, 9 words (F8 08 / F9 10 / FA 00 / D1 01 / 4A 05 / 42 00 / 38 03 / 12 82 / B8 00), correct CSUM.
   - 9 mem_we pulses at addr 0..8 with matching data.
   - Then done=1, cpu_hold=0, words_loaded=9.
2. Frame 01 12 34 27 → one write of 0x1234 at addr 0, then done=1. Same frame with CSUM 0x28 → error=1, cpu_hold=1, and RAM[0] is still 0x1234.
3. COUNT=00 with 512 data bytes and correct CSUM → 256 writes, words_loaded=256, mem_addr wraps to 0, done=1.
4. TIMEOUT_CYCLES=16:
   - Send 01 12, then idle 16 cycles → error=1 exactly 16 cycles after the last accept.
   - Repeat with a byte arriving in the 16th cycle → no error.
5. start pulse after 3 words of a 9-word frame → IDLE, mem_addr=0. A fresh full frame then loads correctly.
6. Assert reset asynchronously while mem_we=1 → mem_we=0 and cpu_hold=1 immediately. After release, all outputs are at reset values.
